// File: rtl/uart_rx_ctrl_if.sv
// Receive-byte handshake between uart_rx_ctrl and the PicoBlaze port logic.
//   rx_data     : received byte
//   rx_ready    : byte available, held until acknowledged
//   rd_ack      : one-cycle read acknowledge from the port logic
//   framing_err : stop bit was 0 on the presented frame
//   parity_err  : parity mismatch on the presented frame
//   overrun_err : a frame completed while rx_ready was still set
// master = receive controller, slave = port logic.
interface uart_rx_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rd_ack;
  logic       framing_err;
  logic       parity_err;
  logic       overrun_err;

  modport master (
    output rx_data,
    output rx_ready,
    output framing_err,
    output parity_err,
    output overrun_err,
    input  rd_ack
  );

  modport slave (
    input  rx_data,
    input  rx_ready,
    input  framing_err,
    input  parity_err,
    input  overrun_err,
    output rd_ack
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Sequencer for the UART receive shift register (lb_shiftreg_rx).
// Synchronises the serial line, validates the start bit at mid-bit, times
// mid-bit sampling from a 16x baud tick, issues one shift strobe per frame bit
// and checks stop/parity once the 11-bit frame sits in the shift register.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   baud_tick  : single-cycle pulse at OVERSAMPLE x baud rate
//   rx         : asynchronous serial input, idle high
//   sr_shift   : registered one-cycle shift strobe to the shift register
//   sr_data    : registered bit to shift in, valid with sr_shift
//   sr_q       : shift register contents ([0] start, [8:1] data, [9] parity, [10] stop)
//   host       : byte/flags/ready/ack handshake to the port logic
//   busy       : controller not idle
module uart_rx_ctrl #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  rx,
  output logic                  sr_shift,
  output logic                  sr_data,
  input  logic [10:0]           sr_q,
  uart_rx_ctrl_if.master        host,
  output logic                  busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  typedef logic [TickW-1:0] tick_t;
  localparam tick_t HalfM1 = tick_t'(OVERSAMPLE / 2 - 1);
  localparam tick_t FullM1 = tick_t'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StSettle, StLoad} state_e;

  state_e      state_q, state_d;
  tick_t       tick_q, tick_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  sync_q;
  logic        rx_s;
  logic        armed_q, armed_d;
  logic        shift_q, shift_d;
  logic        sdata_q, sdata_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        ferr_q, ferr_d;
  logic        perr_q, perr_d;
  logic        oerr_q, oerr_d;
  logic        stop_bad, par_bad;

  // Synchroniser resets low so a line held low through reset never arms.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  assign stop_bad = ~sr_q[10];
  assign par_bad  = PARITY_EN & ((^sr_q[9:1]) != PARITY_ODD);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = 1'b0;
    sdata_d = 1'b0;
    armed_d = armed_q | rx_s;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    oerr_d  = oerr_q;

    unique case (state_q)
      StIdle: begin
        if (!rx_s && armed_q) begin
          state_d = StStart;
          tick_d  = '0;
        end
      end
      StStart: begin
        if (baud_tick) begin
          if (tick_q == HalfM1) begin
            if (!rx_s) begin
              shift_d = 1'b1;
              sdata_d = 1'b0;
              tick_d  = '0;
              bit_d   = 4'd1;
              state_d = StData;
            end else begin
              state_d = StIdle;  // glitch, not a start bit
            end
          end else begin
            tick_d = tick_q + tick_t'(1);
          end
        end
      end
      StData: begin
        if (baud_tick) begin
          if (tick_q == FullM1) begin
            shift_d = 1'b1;
            sdata_d = rx_s;
            tick_d  = '0;
            bit_d   = bit_q + 4'd1;
            if (bit_q == 4'd10) state_d = StSettle;
          end else begin
            tick_d = tick_q + tick_t'(1);
          end
        end
      end
      StSettle: begin
        // The stop-bit strobe is in flight; a low stop bit is a break, so
        // disarm until the line has been seen high again.
        state_d = StLoad;
        if (!sdata_q) armed_d = 1'b0;
      end
      StLoad: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StLoad) begin
      if (!ready_q || host.rd_ack) begin
        data_d  = sr_q[8:1];
        ready_d = 1'b1;
        ferr_d  = stop_bad;
        perr_d  = par_bad;
        oerr_d  = 1'b0;
      end else begin
        oerr_d  = 1'b1;  // previous byte unread, new frame dropped
      end
    end else if (host.rd_ack && ready_q) begin
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      oerr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      armed_q <= 1'b0;
      shift_q <= 1'b0;
      sdata_q <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      armed_q <= armed_d;
      shift_q <= shift_d;
      sdata_q <= sdata_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign sr_shift         = shift_q;
  assign sr_data          = sdata_q;
  assign host.rx_data     = data_q;
  assign host.rx_ready    = ready_q;
  assign host.framing_err = ferr_q;
  assign host.parity_err  = perr_q;
  assign host.overrun_err = oerr_q;
  assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: models the external 11-bit shift register,
// drives serial frames at 16 baud ticks per bit (one tick every 4 clk) and
// checks byte, flags, strobe counts and handshake behaviour.
module tb_uart_rx_ctrl;
  localparam int BitClk = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        baud_tick = 1'b0;
  logic        rx = 1'b1;
  logic        ack = 1'b0;
  logic        sr_shift, sr_data, busy;
  logic        sr_shift2, sr_data2, busy2;
  logic [10:0] sr_q = '0;
  logic [10:0] sr_q2 = '0;
  logic [1:0]  div = '0;
  int          cyc = 0;
  int          shift_cnt = 0;
  int          last_shift_cyc = 0;
  int          ready_rise_cyc = 0;
  logic        ready_prev = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          n0;

  uart_rx_ctrl_if bus ();
  uart_rx_ctrl_if bus2 ();
  assign bus.rd_ack  = ack;
  assign bus2.rd_ack = ack;

  uart_rx_ctrl #(.OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx), .sr_shift(sr_shift),
    .sr_data(sr_data), .sr_q(sr_q), .host(bus.master), .busy(busy)
  );

  uart_rx_ctrl #(.OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx), .sr_shift(sr_shift2),
    .sr_data(sr_data2), .sr_q(sr_q2), .host(bus2.master), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div       <= div + 2'd1;
    baud_tick <= (div == 2'd3);
  end

  // Shift register model: first bit received ends up in bit 0.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sr_shift) begin
      sr_q           <= {sr_data, sr_q[10:1]};
      shift_cnt      <= shift_cnt + 1;
      last_shift_cyc <= cyc;
    end
    if (sr_shift2) sr_q2 <= {sr_data2, sr_q2[10:1]};
    if (bus.rx_ready && !ready_prev) ready_rise_cyc <= cyc;
    ready_prev <= bus.rx_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends start, 8 data bits LSB first, parity, stop. With ack_load set,
  // rd_ack is pulsed in the cycle after the 11th strobe (the LOAD cycle).
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit ack_load);
    logic [10:0] f;
    bit pend;
    f = {stop, par, d, 1'b0};
    pend = 0;
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      for (int k = 0; k < BitClk; k++) begin
        @(negedge clk);
        ack = 1'b0;
        if (pend) begin
          ack  = 1'b1;
          pend = 0;
        end
        if (ack_load && sr_shift && i == 10) pend = 1;
      end
    end
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  function automatic logic [3:0] flags();
    return {bus.rx_ready, bus.framing_err, bus.parity_err, bus.overrun_err};
  endfunction

  initial begin
    logic [10:0] f;
    // Reset with the line idle
    idle(5);
    reset = 1'b0;
    check("reset_data", bus.rx_data, 8'h00);
    check("reset_flags", {flags(), busy, sr_shift}, 6'b0);
    idle(100);

    // 0xA5, even parity 0, good stop
    n0 = shift_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check("a5_shifts", shift_cnt - n0, 11);
    check("a5_data", bus.rx_data, 8'hA5);
    check("a5_flags", flags(), 4'b1000);
    check("a5_latency", ready_rise_cyc - last_shift_cyc, 2);
    check("a5_busy", busy, 1'b0);
    pulse_ack();
    check("a5_ack_flags", flags(), 4'b0000);

    // Start glitch of 4 baud ticks
    n0 = shift_cnt;
    rx = 1'b0;
    idle(8);
    check("glitch_busy_mid", busy, 1'b1);
    idle(8);
    rx = 1'b1;
    idle(BitClk);
    check("glitch_shifts", shift_cnt - n0, 0);
    check("glitch_busy", busy, 1'b0);
    check("glitch_ready", bus.rx_ready, 1'b0);

    // Break: stop bit 0, line stays low
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    check("brk_data", bus.rx_data, 8'h3C);
    check("brk_flags", flags(), 4'b1100);
    n0 = shift_cnt;
    idle(3 * BitClk);
    check("brk_low_shifts", shift_cnt - n0, 0);
    check("brk_low_busy", busy, 1'b0);
    pulse_ack();
    check("brk_ack_flags", flags(), 4'b0000);
    rx = 1'b1;
    idle(BitClk);
    send_frame(8'h55, 1'b0, 1'b1, 0);
    check("rearm_data", bus.rx_data, 8'h55);
    check("rearm_flags", flags(), 4'b1000);
    pulse_ack();

    // Parity: 0x01 with parity bit 0 is wrong for even parity
    send_frame(8'h01, 1'b0, 1'b1, 0);
    check("par_data", bus.rx_data, 8'h01);
    check("par_flags", flags(), 4'b1010);
    check("par_noen_data", bus2.rx_data, 8'h01);
    check("par_noen_flags", {bus2.rx_ready, bus2.parity_err}, 2'b10);
    pulse_ack();
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("par_ok_data", bus.rx_data, 8'h07);
    check("par_ok_flags", flags(), 4'b1000);
    pulse_ack();

    // Overrun: second frame dropped while unread
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 0);
    check("ovr_data", bus.rx_data, 8'h11);
    check("ovr_flags", flags(), 4'b1001);
    pulse_ack();
    check("ovr_ack_flags", flags(), 4'b0000);
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 1);
    check("ack_load_data", bus.rx_data, 8'h22);
    check("ack_load_flags", flags(), 4'b1000);
    send_frame(8'h33, 1'b0, 1'b1, 0);
    check("ovr2_flags", flags(), 4'b1001);
    send_frame(8'h44, 1'b0, 1'b1, 1);
    check("ack_ovr_data", bus.rx_data, 8'h44);
    check("ack_ovr_flags", flags(), 4'b1000);

    // Reset after the 5th strobe of a 0x7E frame
    n0 = shift_cnt;
    f = {1'b1, 1'b0, 8'h7E, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = f[i];
      idle(BitClk);
    end
    check("rst_mid_shifts", shift_cnt - n0, 5);
    check("rst_mid_busy_pre", busy, 1'b1);
    rx = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_data", bus.rx_data, 8'h00);
    check("rst_mid_flags", {flags(), busy, sr_shift}, 6'b0);
    n0 = shift_cnt;
    idle(4 * BitClk);
    check("rst_mid_noshift", shift_cnt - n0, 0);
    check("rst_mid_ready", bus.rx_ready, 1'b0);
    n0 = shift_cnt;
    send_frame(8'h7E, 1'b0, 1'b1, 0);
    check("post_rst_shifts", shift_cnt - n0, 11);
    check("post_rst_data", bus.rx_data, 8'h7E);
    check("post_rst_flags", flags(), 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
